// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter.
// Masters can lock the bus for read-modify-write sequences.
// Reads return data from the bus one cycle after the grant.
module bus_arbiter #(
    parameter int width      = 16,
    parameter int addr_width = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m1_req,
    input  logic                  m0_we,
    input  logic                  m1_we,
    input  logic [addr_width-1:0] m0_addr,
    input  logic [addr_width-1:0] m1_addr,
    input  logic [width-1:0]      m0_wdata,
    input  logic [width-1:0]      m1_wdata,
    input  logic                  m0_lock,
    input  logic                  m1_lock,
    output logic                  m0_gnt,
    output logic                  m1_gnt,
    output logic                  m0_rvalid,
    output logic                  m1_rvalid,
    output logic [width-1:0]      m0_rdata,
    output logic [width-1:0]      m1_rdata,
    output logic [addr_width-1:0] addr,
    output logic [width-1:0]      data_write,
    output logic                  w_strobe,
    input  logic [width-1:0]      data_read
);

    // prio: 0 = m0 wins a tie, 1 = m1 wins a tie
    logic prio_q, prio_d;
    logic lock_vld_q, lock_vld_d;
    logic lock_own_q, lock_own_d;
    logic rd_pend_q, rd_pend_d;
    logic rd_own_q, rd_own_d;
    logic g0, g1;

    // Grant decision: a live lock owner wins outright.
    // Once the owner drops req, normal arbitration applies in the same cycle.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (!reset) begin
            if (lock_vld_q && !lock_own_q && m0_req) begin
                g0 = 1'b1;
            end else if (lock_vld_q && lock_own_q && m1_req) begin
                g1 = 1'b1;
            end else if (m0_req && m1_req) begin
                if (prio_q) g1 = 1'b1;
                else        g0 = 1'b1;
            end else if (m0_req) begin
                g0 = 1'b1;
            end else if (m1_req) begin
                g1 = 1'b1;
            end
        end
    end

    // Next-state: round-robin pointer, lock ownership, pending read tracking
    always_comb begin
        prio_d     = prio_q;
        lock_vld_d = 1'b0;
        lock_own_d = lock_own_q;
        rd_pend_d  = 1'b0;
        rd_own_d   = rd_own_q;
        if (g0) begin
            prio_d     = 1'b1;
            lock_vld_d = m0_lock;
            lock_own_d = 1'b0;
            rd_pend_d  = !m0_we;
            rd_own_d   = 1'b0;
        end else if (g1) begin
            prio_d     = 1'b0;
            lock_vld_d = m1_lock;
            lock_own_d = 1'b1;
            rd_pend_d  = !m1_we;
            rd_own_d   = 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q     <= 1'b0;
            lock_vld_q <= 1'b0;
            lock_own_q <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_own_q   <= 1'b0;
        end else begin
            prio_q     <= prio_d;
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
            rd_pend_q  <= rd_pend_d;
            rd_own_q   <= rd_own_d;
        end
    end

    // Bus mux and read return.
    // Reset masks an in-flight read so it never reports valid.
    always_comb begin
        m0_gnt     = g0;
        m1_gnt     = g1;
        addr       = '0;
        data_write = '0;
        w_strobe   = 1'b0;
        if (g0) begin
            addr       = m0_addr;
            data_write = m0_wdata;
            w_strobe   = m0_we;
        end else if (g1) begin
            addr       = m1_addr;
            data_write = m1_wdata;
            w_strobe   = m1_we;
        end
        m0_rvalid = rd_pend_q && !rd_own_q && !reset;
        m1_rvalid = rd_pend_q &&  rd_own_q && !reset;
        m0_rdata  = m0_rvalid ? data_read : '0;
        m1_rdata  = m1_rvalid ? data_read : '0;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter.
// Includes a memory model behind the bus and a scoreboard of expected read returns.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock;
    logic [8:0]  m0_addr, m1_addr;
    logic [15:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, w_strobe;
    logic [15:0] m0_rdata, m1_rdata, data_write, data_read;
    logic [8:0]  addr;

    logic [15:0] mem [512];
    logic [15:0] ref_mem [512];

    typedef struct {
        int          due;
        bit          m;
        logic [15:0] d;
    } rd_t;
    rd_t q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.width(16), .addr_width(9)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_lock(m0_lock), .m1_lock(m1_lock),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .addr(addr), .data_write(data_write), .w_strobe(w_strobe),
        .data_read(data_read)
    );

    // Memory on the bus: registered read, one-cycle latency
    always @(posedge clk) begin
        if (w_strobe) mem[addr] <= data_write;
        data_read <= mem[addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
        end
    endtask

    // Drive one cycle, check all outputs at the falling edge, then advance.
    task automatic step(input bit rst,
                        input bit r0, input bit we0, input logic [8:0] a0,
                        input logic [15:0] d0, input bit l0,
                        input bit r1, input bit we1, input logic [8:0] a1,
                        input logic [15:0] d1, input bit l1,
                        input bit eg0, input bit eg1);
        logic [8:0]  ea;
        logic [15:0] ed, erd0, erd1;
        bit          ews, erv0, erv1;
        reset = rst;
        m0_req = r0; m0_we = we0; m0_addr = a0; m0_wdata = d0; m0_lock = l0;
        m1_req = r1; m1_we = we1; m1_addr = a1; m1_wdata = d1; m1_lock = l1;
        @(negedge clk);
        ea = '0; ed = '0; ews = 1'b0;
        if (eg0) begin ea = a0; ed = d0; ews = we0; end
        if (eg1) begin ea = a1; ed = d1; ews = we1; end
        chk("m0_gnt", 32'(m0_gnt), 32'(eg0));
        chk("m1_gnt", 32'(m1_gnt), 32'(eg1));
        chk("addr", 32'(addr), 32'(ea));
        chk("data_write", 32'(data_write), 32'(ed));
        chk("w_strobe", 32'(w_strobe), 32'(ews));
        erv0 = 1'b0; erv1 = 1'b0; erd0 = '0; erd1 = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            rd_t e;
            e = q.pop_front();
            if (!rst) begin
                if (e.m) begin erv1 = 1'b1; erd1 = e.d; end
                else     begin erv0 = 1'b1; erd0 = e.d; end
            end
        end
        chk("m0_rvalid", 32'(m0_rvalid), 32'(erv0));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(erv1));
        chk("m0_rdata", 32'(m0_rdata), 32'(erd0));
        chk("m1_rdata", 32'(m1_rdata), 32'(erd1));
        if (ews) ref_mem[ea] = ed;
        else if (eg0 || eg1) q.push_back('{due: cyc + 1, m: eg1, d: ref_mem[ea]});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input bit rst);
        step(rst, 0, 0, 9'h0, 16'h0, 0, 0, 0, 9'h0, 16'h0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i]     = 16'(i * 3 + 1);
            ref_mem[i] = 16'(i * 3 + 1);
        end
        mem[5] = 16'hBEEF;      ref_mem[5] = 16'hBEEF;
        mem[9'h100] = 16'h1234; ref_mem[9'h100] = 16'h1234;
        mem[3] = 16'h0303;      ref_mem[3] = 16'h0303;
        @(posedge clk);
        #1;

        // Reset: nothing granted, bus idle
        idle(1);
        idle(1);
        idle(0);

        // Single m0 read of 0x005, data returns the next cycle
        step(0, 1, 0, 9'h005, 16'h0, 0, 0, 0, 9'h0, 16'h0, 0, 1, 0);
        idle(0);

        // Fresh reset, then both masters write continuously: m0 first, alternating
        idle(1);
        for (int i = 0; i < 4; i++)
            step(0, 1, 1, 9'h020, 16'hA000 + 16'(i), 0,
                    1, 1, 9'h030, 16'hB000 + 16'(i), 0, (i % 2) == 0, (i % 2) == 1);

        // Move pointer to m1, then a locked m1 write/read pair while m0 keeps requesting
        step(0, 1, 1, 9'h041, 16'h4141, 0, 0, 0, 9'h0, 16'h0, 0, 1, 0);
        step(0, 1, 1, 9'h040, 16'h4040, 0, 1, 1, 9'h010, 16'h5A5A, 1, 0, 1);
        step(0, 1, 1, 9'h040, 16'h4040, 0, 1, 0, 9'h010, 16'h0, 0, 0, 1);
        step(0, 1, 1, 9'h040, 16'h4040, 0, 0, 0, 9'h0, 16'h0, 0, 1, 0);

        // m0 reads gpio region, m1 reads 0x003 in m0's rvalid cycle
        step(0, 1, 0, 9'h100, 16'h0, 0, 0, 0, 9'h0, 16'h0, 0, 1, 0);
        step(0, 0, 0, 9'h0, 16'h0, 0, 1, 0, 9'h003, 16'h0, 0, 0, 1);
        idle(0);

        // m0 locks; holds the bus against m1 even though m1 has priority; then releases by dropping req
        step(0, 1, 1, 9'h050, 16'h0050, 1, 0, 0, 9'h0, 16'h0, 0, 1, 0);
        step(0, 1, 0, 9'h050, 16'h0, 0, 1, 1, 9'h060, 16'h0060, 0, 1, 0);
        step(0, 0, 0, 9'h0, 16'h0, 0, 1, 1, 9'h060, 16'h0060, 0, 0, 1);

        // Read grant followed by a one-cycle reset: the read is dropped, m0 wins next
        step(0, 0, 0, 9'h0, 16'h0, 0, 1, 0, 9'h005, 16'h0, 0, 0, 1);
        idle(1);
        step(0, 1, 0, 9'h003, 16'h0, 0, 1, 1, 9'h070, 16'h7070, 0, 1, 0);
        idle(0);

        // Ten idle cycles leave the pointer on m1
        for (int i = 0; i < 10; i++) idle(0);
        step(0, 1, 1, 9'h080, 16'h8080, 0, 1, 1, 9'h090, 16'h9090, 0, 0, 1);
        idle(0);

        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
